dmem_arbiter: RTL and testbench

- Shares the single-port 2048x32 data memory between two requesters: port 0 (CPU load/store) and port 1 (VGA framebuffer reader / DMA).
- Sits between the requesters and dmem.
- Arbitration is round-robin with a bounded burst, so neither port starves.
- Adds address checking and returns read data with a per-port valid strobe.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arb_tagpipe.sv | 33 +++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Every arbiter file imports this package.
package dmem_arb_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_VGA = 1'b1
    } port_id_t;

    localparam int MEM_WORDS_DEF = 2048;
    localparam int IDX_W_DEF     = 11;

    // One in-flight access, tracked until its response slot arrives.
    typedef struct packed {
        logic     valid;
        port_id_t port;
        logic     is_read;
        logic     fault;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arb_tagpipe.sv
// Delay line that carries access tags for RD_LATENCY cycles so each tag lines up with the memory's read data.
// The synchronous active-low clear drops every in-flight tag.
module dmem_arb_tagpipe
    import dmem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    generate
        if (RD_LATENCY == 0) begin : g_comb
            assign tag_out = tag_in;
        end else begin : g_pipe
            rd_tag_t stage [RD_LATENCY];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= tag_in;
                    for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
                end
            end

            assign tag_out = stage[RD_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded bursts for the shared single-port dmem.
// Adds address fault checking and returns read data with a valid strobe to each port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 32,
    parameter  int MEM_WORDS  = MEM_WORDS_DEF,
    parameter  int RD_LATENCY = 1,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_W      = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int             BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0]  BURST_ONE = BW'(1);

    port_id_t          owner, owner_d;
    logic [BW-1:0]     burst_cnt, burst_d;
    logic              sel_we, fault, any_gnt, resp_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd, resp_data, p0_rdata_q, p1_rdata_q;
    rd_tag_t           tag_in, tag_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= PORT_VGA;
            burst_cnt <= BURST_MAX;
        end else begin
            owner     <= owner_d;
            burst_cnt <= burst_d;
        end
    end

    // Grants are suppressed while reset is asserted so no access slips through.
    always_comb begin
        p0_gnt  = 1'b0;
        p1_gnt  = 1'b0;
        owner_d = owner;
        burst_d = burst_cnt;
        if (rst_n) begin
            unique case ({p1_req, p0_req})
                2'b01: begin
                    p0_gnt = 1'b1;
                    if (owner == PORT_CPU) begin
                        burst_d = (burst_cnt < BURST_MAX) ? burst_cnt + BURST_ONE : BURST_MAX;
                    end else begin
                        owner_d = PORT_CPU;
                        burst_d = BURST_ONE;
                    end
                end
                2'b10: begin
                    p1_gnt = 1'b1;
                    if (owner == PORT_VGA) begin
                        burst_d = (burst_cnt < BURST_MAX) ? burst_cnt + BURST_ONE : BURST_MAX;
                    end else begin
                        owner_d = PORT_VGA;
                        burst_d = BURST_ONE;
                    end
                end
                2'b11: begin
                    if (burst_cnt < BURST_MAX) begin
                        p0_gnt  = (owner == PORT_CPU);
                        p1_gnt  = (owner == PORT_VGA);
                        burst_d = burst_cnt + BURST_ONE;
                    end else begin
                        p0_gnt  = (owner == PORT_VGA);
                        p1_gnt  = (owner == PORT_CPU);
                        owner_d = (owner == PORT_CPU) ? PORT_VGA : PORT_CPU;
                        burst_d = BURST_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign any_gnt  = p0_gnt | p1_gnt;
    assign sel_we   = p1_gnt ? p1_we    : p0_we;
    assign sel_addr = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wd   = p1_gnt ? p1_wdata : p0_wdata;
    assign fault    = (sel_addr[1:0] != 2'b00) || (sel_addr[ADDR_W-1:IDX_W+2] != '0);

    assign mem_we   = any_gnt & sel_we & ~fault;
    assign mem_addr = sel_addr[IDX_W+1:2];
    assign mem_wd   = sel_wd;

    assign tag_in.valid   = any_gnt;
    assign tag_in.port    = p1_gnt ? PORT_VGA : PORT_CPU;
    assign tag_in.is_read = ~sel_we;
    assign tag_in.fault   = fault;

    dmem_arb_tagpipe #(.RD_LATENCY(RD_LATENCY)) u_tagpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // A faulted read still completes, but it returns zero instead of memory contents.
    assign resp_ok   = rst_n & tag_out.valid;
    assign resp_data = tag_out.fault ? '0 : mem_rd;

    assign p0_rvalid = resp_ok & tag_out.is_read & (tag_out.port == PORT_CPU);
    assign p1_rvalid = resp_ok & tag_out.is_read & (tag_out.port == PORT_VGA);
    assign p0_err    = resp_ok & tag_out.fault   & (tag_out.port == PORT_CPU);
    assign p1_err    = resp_ok & tag_out.fault   & (tag_out.port == PORT_VGA);

    assign p0_rdata  = p0_rvalid ? resp_data : p0_rdata_q;
    assign p1_rdata  = p1_rvalid ? resp_data : p1_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            p0_rdata_q <= p0_rdata;
            p1_rdata_q <= p1_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one registered-RAM build plus one combinational-RAM build,
// each attached to its own behavioural memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wd, mem_rd;

    logic        q0_req, q0_we, q1_req, q1_we;
    logic [31:0] q0_addr, q0_wdata, q1_addr, q1_wdata;
    logic        q0_gnt, q0_rvalid, q0_err, q1_gnt, q1_rvalid, q1_err;
    logic [31:0] q0_rdata, q1_rdata;
    logic        qmem_we;
    logic [10:0] qmem_addr;
    logic [31:0] qmem_wd, qmem_rd;

    logic [31:0] mem1 [0:2047];
    logic [31:0] mem0 [0:2047];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    dmem_arbiter #(.RD_LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(q0_req), .p0_we(q0_we), .p0_addr(q0_addr), .p0_wdata(q0_wdata),
        .p0_gnt(q0_gnt), .p0_rvalid(q0_rvalid), .p0_rdata(q0_rdata), .p0_err(q0_err),
        .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
        .p1_gnt(q1_gnt), .p1_rvalid(q1_rvalid), .p1_rdata(q1_rdata), .p1_err(q1_err),
        .mem_we(qmem_we), .mem_addr(qmem_addr), .mem_wd(qmem_wd), .mem_rd(qmem_rd)
    );

    // Registered-read RAM for the latency-1 build.
    always @(posedge clk) begin
        if (mem_we) mem1[mem_addr] <= mem_wd;
        mem_rd <= mem1[mem_addr];
    end

    // Combinational-read RAM for the latency-0 build.
    always @(posedge clk) begin
        if (qmem_we) mem0[qmem_addr] <= qmem_wd;
    end
    assign qmem_rd = mem0[qmem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of requests just after the rising edge, then waits for the falling edge so checks can run.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        q0_req = 0; q0_we = 0; q0_addr = 0; q0_wdata = 0;
        q1_req = 0; q1_we = 0; q1_addr = 0; q1_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_p0_gnt",    32'(p0_gnt),    32'd0);
        checkOutput("rst_p1_gnt",    32'(p1_gnt),    32'd0);
        checkOutput("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        checkOutput("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        checkOutput("rst_p0_err",    32'(p0_err),    32'd0);
        checkOutput("rst_mem_we",    32'(mem_we),    32'd0);
        checkOutput("rst_p0_rdata",  p0_rdata,       32'd0);
        checkOutput("rst_p1_rdata",  p1_rdata,       32'd0);

        $display("[TB] write then read-after-write");
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        checkOutput("t1_wr_gnt",   32'(p0_gnt),   32'd1);
        checkOutput("t1_wr_we",    32'(mem_we),   32'd1);
        checkOutput("t1_wr_addr",  32'(mem_addr), 32'd4);
        checkOutput("t1_wr_wd",    mem_wd,        32'hDEADBEEF);
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        checkOutput("t1_rd_gnt",    32'(p0_gnt),    32'd1);
        checkOutput("t1_rd_addr",   32'(mem_addr),  32'd4);
        checkOutput("t1_rd_we",     32'(mem_we),    32'd0);
        checkOutput("t1_wr_norv",   32'(p0_rvalid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rvalid",    32'(p0_rvalid), 32'd1);
        checkOutput("t1_rdata",     p0_rdata,       32'hDEADBEEF);
        checkOutput("t1_noerr",     32'(p0_err),    32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_rv_drop",   32'(p0_rvalid), 32'd0);
        checkOutput("t1_rdata_hold", p0_rdata,      32'hDEADBEEF);

        $display("[TB] contested round robin");
        doReset();
        for (int k = 0; k < 12; k++) begin
            logic exp1;
            exp1 = ((k / 4) % 2) == 1;
            applyStimulus(1, 1, 32'h40, 32'h11111111, 1, 1, 32'h44, 32'h22222222);
            checkOutput($sformatf("t2_p0_gnt_%0d", k), 32'(p0_gnt), 32'(!exp1));
            checkOutput($sformatf("t2_p1_gnt_%0d", k), 32'(p1_gnt), 32'(exp1));
            checkOutput($sformatf("t2_addr_%0d", k), 32'(mem_addr), exp1 ? 32'h11 : 32'h10);
        end

        $display("[TB] p1 streaming reads");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 32'h1000 + 32'(4 * k), 32'hA5000000 + 32'(k));
            checkOutput($sformatf("t3_wr_gnt_%0d", k), 32'(p1_gnt), 32'd1);
        end
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) applyStimulus(0, 0, 0, 0, 1, 0, 32'h1000 + 32'(4 * k), 0);
            else        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t3_p1_gnt_%0d", k), 32'(p1_gnt), 32'(k < 10));
            checkOutput($sformatf("t3_p0_gnt_%0d", k), 32'(p0_gnt), 32'd0);
            checkOutput($sformatf("t3_p0_rv_%0d", k), 32'(p0_rvalid), 32'd0);
            checkOutput($sformatf("t3_p1_rv_%0d", k), 32'(p1_rvalid), 32'(k > 0));
            if (k > 0)
                checkOutput($sformatf("t3_p1_rdata_%0d", k), p1_rdata, 32'hA5000000 + 32'(k - 1));
        end

        $display("[TB] faulted accesses");
        applyStimulus(1, 1, 32'h2010, 32'hBAD0BAD0, 0, 0, 0, 0);
        checkOutput("t4_oor_gnt",  32'(p0_gnt),   32'd1);
        checkOutput("t4_oor_we",   32'(mem_we),   32'd0);
        checkOutput("t4_oor_addr", 32'(mem_addr), 32'd4);
        applyStimulus(1, 0, 32'h6, 0, 0, 0, 0, 0);
        checkOutput("t4_mis_gnt",  32'(p0_gnt),    32'd1);
        checkOutput("t4_mis_addr", 32'(mem_addr),  32'd1);
        checkOutput("t4_oor_err",  32'(p0_err),    32'd1);
        checkOutput("t4_oor_norv", 32'(p0_rvalid), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_mis_err",   32'(p0_err),    32'd1);
        checkOutput("t4_mis_rv",    32'(p0_rvalid), 32'd1);
        checkOutput("t4_mis_rdata", p0_rdata,       32'd0);
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
        checkOutput("t4_chk_gnt",  32'(p0_gnt), 32'd1);
        checkOutput("t4_err_drop", 32'(p0_err), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_mem_kept_rv", 32'(p0_rvalid), 32'd1);
        checkOutput("t4_mem_kept",    p0_rdata,       32'hDEADBEEF);

        $display("[TB] reset flushes in-flight read");
        doReset();
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h1000, 0);
        checkOutput("t5_gnt", 32'(p1_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        checkOutput("t5_rv_in_rst",  32'(p1_rvalid), 32'd0);
        checkOutput("t5_gnt_in_rst", 32'(p1_gnt),    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t5_rv_after", 32'(p1_rvalid), 32'd0);
        applyStimulus(1, 0, 32'h10, 0, 1, 0, 32'h1000, 0);
        checkOutput("t5_p0_first", 32'(p0_gnt), 32'd1);
        checkOutput("t5_p1_wait",  32'(p1_gnt), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] zero-latency build");
        @(posedge clk);
        #1;
        q0_req = 1; q0_we = 1; q0_addr = 32'h1C; q0_wdata = 32'h12345678;
        @(negedge clk);
        checkOutput("t6_wr_gnt", 32'(q0_gnt),    32'd1);
        checkOutput("t6_wr_rv",  32'(q0_rvalid), 32'd0);
        @(posedge clk);
        #1;
        q0_we = 0;
        @(negedge clk);
        checkOutput("t6_rd_gnt",   32'(q0_gnt),    32'd1);
        checkOutput("t6_rd_rv",    32'(q0_rvalid), 32'd1);
        checkOutput("t6_rd_rdata", q0_rdata,       32'h12345678);
        @(posedge clk);
        #1;
        q0_req = 0;
        @(negedge clk);
        checkOutput("t6_rv_drop",  32'(q0_rvalid), 32'd0);
        checkOutput("t6_rd_hold",  q0_rdata,       32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
